// File: rtl/tracker_pkg.sv
// Shared FSM state type and output widths for the marker centroid tracker.
package tracker_pkg;
   typedef enum logic [2:0] {IDLE, DIV_X, DIV_Y, DIV_Z, DONE} tracker_state_t;
   localparam int H_W   = 11;
   localparam int V_W   = 10;
   localparam int X_W   = 12;
   localparam int Y_W   = 12;
   localparam int Z_W   = 14;
   localparam int Z_MAX = 16383;
endpackage

// File: rtl/marker_centroid_tracker_seq_divider.sv
// Restoring divider, one quotient bit per cycle; done_out pulses SUM_W+1 cycles after start_in.
module seq_divider #(
   parameter int SUM_W = 32,
   parameter int CNT_W = 20
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic [SUM_W-1:0] dividend_in,
   input  logic [CNT_W-1:0] divisor_in,
   output logic [SUM_W-1:0] quotient_out,
   output logic             done_out
);
   localparam int STEP_W = $clog2(SUM_W + 1);

   logic              run;
   logic [STEP_W-1:0] steps;
   logic [CNT_W-1:0]  divisor;
   logic [CNT_W-1:0]  rem;
   logic [SUM_W-1:0]  quo;
   logic [CNT_W:0]    trial;

   // quo doubles as the dividend shift register: its MSB feeds the partial remainder
   always_comb trial = {rem, quo[SUM_W-1]};

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         run   <= 1'b0;
         steps <= '0;
      end else if (start_in) begin
         run   <= 1'b1;
         steps <= STEP_W'(SUM_W);
      end else if (run) begin
         if (steps == '0) run   <= 1'b0;
         else             steps <= steps - 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (start_in) begin
         quo     <= dividend_in;
         rem     <= '0;
         divisor <= divisor_in;
      end else if (run && steps != '0) begin
         if (trial >= {1'b0, divisor}) begin
            rem <= CNT_W'(trial - {1'b0, divisor});
            quo <= {quo[SUM_W-2:0], 1'b1};
         end else begin
            rem <= trial[CNT_W-1:0];
            quo <= {quo[SUM_W-2:0], 1'b0};
         end
      end
   end

   assign done_out     = run && (steps == '0);
   assign quotient_out = quo;
endmodule

// File: rtl/marker_centroid_tracker.sv
// Accumulates masked pixel positions per frame and reports centroid (x, y) and depth z = Z_K / area.
module marker_centroid_tracker
   import tracker_pkg::*;
#(
   parameter int MIN_PIXELS = 16,
   parameter int Z_K        = 2_000_000,
   parameter int SUM_W      = 32,
   parameter int CNT_W      = 20
) (
   input  logic           clk_in,
   input  logic           rst_in,
   input  logic [H_W-1:0] hcount_in,
   input  logic [V_W-1:0] vcount_in,
   input  logic           pixel_valid_in,
   input  logic           mask_in,
   input  logic           frame_done_in,
   output logic [X_W-1:0] x_out,
   output logic [Y_W-1:0] y_out,
   output logic [Z_W-1:0] z_out,
   output logic           found_out,
   output logic           valid_out,
   output logic           busy_out,
   output logic           overrun_out
);
   tracker_state_t   state, next_state;
   logic             hit, accept, enough, busy, start, restart, div_done;
   logic [SUM_W-1:0] sum_x, sum_y, tot_x, tot_y, snap_x, snap_y, dividend, quotient;
   logic [CNT_W-1:0] count, tot_cnt, snap_cnt, divisor;
   logic [H_W-1:0]   x_q;
   logic [V_W-1:0]   y_q;
   logic [Z_W-1:0]   z_q;
   logic             found_q;

   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
      logic [SUM_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[SUM_W] ? '1 : s[SUM_W-1:0];
   endfunction

   function automatic logic [Z_W-1:0] sat_z(input logic [SUM_W-1:0] q);
      return (q > SUM_W'(Z_MAX)) ? Z_W'(Z_MAX) : q[Z_W-1:0];
   endfunction

   // Frame totals including the current pixel, so the frame_done cycle's pixel is counted
   always_comb begin
      hit     = pixel_valid_in && mask_in;
      tot_x   = hit ? sat_add(sum_x, SUM_W'(hcount_in)) : sum_x;
      tot_y   = hit ? sat_add(sum_y, SUM_W'(vcount_in)) : sum_y;
      tot_cnt = (hit && count != '1) ? count + 1'b1 : count;
      accept  = frame_done_in && (state == IDLE);
      enough  = (tot_cnt != '0) && (tot_cnt >= CNT_W'(MIN_PIXELS));
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         sum_x <= '0;
         sum_y <= '0;
         count <= '0;
      end else if (frame_done_in) begin
         sum_x <= '0;
         sum_y <= '0;
         count <= '0;
      end else begin
         sum_x <= tot_x;
         sum_y <= tot_y;
         count <= tot_cnt;
      end
   end

   // The X divide launches in the frame_done cycle straight from the live totals
   always_comb begin
      dividend = snap_x;
      divisor  = snap_cnt;
      if (state == IDLE) begin
         dividend = tot_x;
         divisor  = tot_cnt;
      end else if (state == DIV_Y) begin
         dividend = snap_y;
      end else if (state == DIV_Z) begin
         dividend = SUM_W'(Z_K);
      end
   end

   seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .start_in     (start),
      .dividend_in  (dividend),
      .divisor_in   (divisor),
      .quotient_out (quotient),
      .done_out     (div_done)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_in) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (accept) next_state = enough ? DIV_X : DONE;
         DIV_X:   if (div_done) next_state = DIV_Y;
         DIV_Y:   if (div_done) next_state = DIV_Z;
         DIV_Z:   if (div_done) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state != IDLE);
      start = (accept && enough) || restart;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         restart <= 1'b0;
         found_q <= 1'b0;
      end else begin
         restart <= ((state == DIV_X) || (state == DIV_Y)) && div_done;
         if (accept) found_q <= enough;
      end
   end

   // Snapshot only when idle: a frame_done during a divide is dropped
   always_ff @(posedge clk_in) begin
      if (accept) begin
         snap_x   <= tot_x;
         snap_y   <= tot_y;
         snap_cnt <= tot_cnt;
      end
      if (div_done && state == DIV_X) x_q <= quotient[H_W-1:0];
      if (div_done && state == DIV_Y) y_q <= quotient[V_W-1:0];
      if (div_done && state == DIV_Z) z_q <= sat_z(quotient);
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         x_out       <= '0;
         y_out       <= '0;
         z_out       <= '0;
         found_out   <= 1'b0;
         valid_out   <= 1'b0;
         overrun_out <= 1'b0;
      end else begin
         valid_out   <= (state == DONE);
         overrun_out <= frame_done_in && busy;
         if (state == DONE) begin
            found_out <= found_q;
            if (found_q) begin
               x_out <= X_W'(x_q);
               y_out <= Y_W'(y_q);
               z_out <= z_q;
            end
         end
      end
   end

   assign busy_out = busy;
endmodule
